// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster generator with a single rectangular sprite.
//
// Ports:
//   clk25mz      pixel clock, all logic on its rising edge
//   rst          synchronous active-high reset
//   box_color    sprite colour {r[2:0],g[2:0],b[1:0]}, sampled every clock
//   bg_color     background colour inside the active area, sampled every clock
//   hsync/vsync  sync pulses, active at SYNC_POL
//   de           output pixel lies in the active area
//   pix_x/pix_y  raw counter coordinates of the output pixel
//   red/green/blue  pixel colour, forced to 0 during blanking
//   frame        completed-frame count, wraps
//   frame_start  one-cycle pulse with output pixel (0,0)
//
// Build option: define VGA_BOUNCE_EN to make the sprite bounce around the
// active area, moving STEP pixels per axis once per frame. Without it the
// sprite is fixed at (BOX_X0, BOX_Y0).
module vga_timing_gen #(
  parameter int H_ACTIVE = 128,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 128,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int BOX_W    = 20,
  parameter int BOX_H    = 20,
  parameter int BOX_X0   = 60,
  parameter int BOX_Y0   = 60,
  parameter int STEP     = 10,
  parameter int FRAME_W  = 16
) (
  input  logic               clk25mz,
  input  logic               rst,
  input  logic [7:0]         box_color,
  input  logic [7:0]         bg_color,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [10:0]        pix_x,
  output logic [10:0]        pix_y,
  output logic [2:0]         red,
  output logic [2:0]         green,
  output logic [1:0]         blue,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_start
);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] VA     = 11'(V_ACTIVE);
  localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_ON  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] BW     = 11'(BOX_W);
  localparam logic [10:0] BH     = 11'(BOX_H);
  localparam logic [10:0] X0     = 11'(BOX_X0);
  localparam logic [10:0] Y0     = 11'(BOX_Y0);
  localparam logic        SP     = 1'(SYNC_POL);

  // Reject geometries the counters and sprite clamp cannot represent.
  if (!(STEP > 0 && BOX_W <= H_ACTIVE && BOX_H <= V_ACTIVE &&
        H_ACTIVE + H_FP + H_SYNC + H_BP < 2048 &&
        V_ACTIVE + V_FP + V_SYNC + V_BP < 2048)) begin : g_bad_params
    $error("vga_timing_gen: unsupported parameter set");
  end

  logic [10:0]        h_q, h_d, v_q, v_d;
  logic [10:0]        bx_q, by_q;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               h_end, eof, active, hit;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
  logic [10:0]        pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [7:0]         rgb_q, rgb_d;

  always_comb begin
    h_end   = h_q == H_LAST;
    eof     = h_end && v_q == V_LAST;
    h_d     = h_end ? '0 : h_q + 11'd1;
    v_d     = eof ? '0 : h_end ? v_q + 11'd1 : v_q;
    frame_d = eof ? frame_q + FRAME_W'(1) : frame_q;
    active  = h_q < HA && v_q < VA;
    hit     = active && h_q >= bx_q && h_q < bx_q + BW && v_q >= by_q && v_q < by_q + BH;
    // Every output is derived from the same (h_q, v_q) so they stay mutually aligned.
    hsync_d = (h_q >= HS_ON && h_q < HS_OFF) ? SP : !SP;
    vsync_d = (v_q >= VS_ON && v_q < VS_OFF) ? SP : !SP;
    de_d    = active;
    pix_x_d = h_q;
    pix_y_d = v_q;
    fs_d    = h_q == '0 && v_q == '0;
    rgb_d   = hit ? box_color : active ? bg_color : 8'h00;
  end

  always_ff @(posedge clk25mz) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
      hsync_q <= !SP;
      vsync_q <= !SP;
      de_q    <= 1'b0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      fs_q    <= fs_d;
      rgb_q   <= rgb_d;
    end
  end

`ifdef VGA_BOUNCE_EN
  localparam logic [10:0] STP   = 11'(STEP);
  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BOX_W);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BOX_H);

  logic [10:0] bx_d, by_d, nx, ny;
  logic        dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;

  // Position only moves on the end-of-frame cycle, so a frame never sees it change.
  always_comb begin
    nx       = bx_q + STP;
    ny       = by_q + STP;
    bx_d     = bx_q;
    by_d     = by_q;
    dx_neg_d = dx_neg_q;
    dy_neg_d = dy_neg_q;
    if (eof) begin
      bx_d     = !dx_neg_q ? (nx > X_MAX ? X_MAX : nx) : (bx_q < STP ? '0 : bx_q - STP);
      dx_neg_d = !dx_neg_q ? nx > X_MAX : bx_q >= STP;
      by_d     = !dy_neg_q ? (ny > Y_MAX ? Y_MAX : ny) : (by_q < STP ? '0 : by_q - STP);
      dy_neg_d = !dy_neg_q ? ny > Y_MAX : by_q >= STP;
    end
  end

  always_ff @(posedge clk25mz) begin
    if (rst) begin
      bx_q     <= X0;
      by_q     <= Y0;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b0;
    end else begin
      bx_q     <= bx_d;
      by_q     <= by_d;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
    end
  end
`else
  assign bx_q = X0;
  assign by_q = Y0;
`endif

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign {red, green, blue} = rgb_q;
  assign frame       = frame_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: table vectors plus per-pixel scoreboard for vga_timing_gen.
module tb_vga_timing_gen;
  localparam int HT = 288;
  localparam int VT = 173;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  box_color = 8'hAA;
  logic [7:0]  bg_color = 8'h01;
  logic        hsync, vsync, de, frame_start;
  logic [10:0] pix_x, pix_y;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic [15:0] frame;

  vga_timing_gen dut (
    .clk25mz(clk), .rst(rst), .box_color(box_color), .bg_color(bg_color),
    .hsync(hsync), .vsync(vsync), .de(de), .pix_x(pix_x), .pix_y(pix_y),
    .red(red), .green(green), .blue(blue), .frame(frame), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [7:0]  rgb;
    logic [15:0] fr;
  } obs_t;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] bx;
    logic [7:0] bg;
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] rgb;
  } vec_t;

  obs_t q[$];
  obs_t rst_obs;
  vec_t tbl[19];
  int   vectors = 0;
  int   miscompares = 0;
  int   p = 0;
  int   decnt = 0;

  // Sprite origin (same for both axes with the default geometry) for frame f.
  function automatic int origin(int f);
    int  b;
    bit  neg;
    b = 60;
    neg = 1'b0;
`ifdef VGA_BOUNCE_EN
    for (int i = 0; i < f; i++) begin
      if (!neg) begin
        if (b + 10 > 108) begin b = 108; neg = 1'b1; end
        else b = b + 10;
      end else begin
        if (b < 10) begin b = 0; neg = 1'b0; end
        else b = b - 10;
      end
    end
`endif
    return b;
  endfunction

  // Expected output for the pp-th pixel after reset release.
  function automatic obs_t model(int pp, logic [7:0] bx, logic [7:0] bg);
    obs_t o;
    int   x, y, org;
    logic hit;
    x     = pp % HT;
    y     = (pp / HT) % VT;
    org   = origin(pp / FT);
    o.x   = 11'(x);
    o.y   = 11'(y);
    o.de  = x < 128 && y < 128;
    o.hs  = !(x >= 144 && x < 240);
    o.vs  = !(y >= 138 && y < 140);
    o.fs  = pp % FT == 0;
    o.fr  = 16'((pp + 1) / FT);
    hit   = o.de && x >= org && x < org + 20 && y >= org && y < org + 20;
    o.rgb = hit ? bx : o.de ? bg : 8'h00;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.x   = pix_x;
    o.y   = pix_y;
    o.de  = de;
    o.hs  = hsync;
    o.vs  = vsync;
    o.fs  = frame_start;
    o.rgb = {red, green, blue};
    o.fr  = frame;
    return o;
  endfunction

  task automatic check(input string name, input obs_t e);
    obs_t a;
    a = sample();
    vectors++;
    if (a !== e) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b fs=%b rgb=%h frame=%0d, want x=%0d y=%0d de=%b hs=%b vs=%b fs=%b rgb=%h frame=%0d",
                 name, a.x, a.y, a.de, a.hs, a.vs, a.fs, a.rgb, a.fr,
                 e.x, e.y, e.de, e.hs, e.vs, e.fs, e.rgb, e.fr);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic tick(input logic r, input logic [7:0] bx, input logic [7:0] bg);
    rst = r;
    box_color = bx;
    bg_color = bg;
    q.push_back(r ? rst_obs : model(p, bx, bg));
    @(posedge clk);
    #2;
    check("scoreboard", q.pop_front());
    if (!r && p < FT && de) decnt++;
    p = r ? 0 : p + 1;
  endtask

  initial begin
    obs_t e;
    int   target;
    rst_obs = '{11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0};
    tbl[0]  = '{0,   0,   8'hAA, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01};
    tbl[1]  = '{127, 0,   8'hAA, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A};
    tbl[2]  = '{128, 0,   8'hAA, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{143, 0,   8'hAA, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{144, 0,   8'hAA, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{239, 0,   8'hAA, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{240, 0,   8'hAA, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[7]  = '{59,  60,  8'hAA, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01};
    tbl[8]  = '{60,  60,  8'hAA, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 8'hAA};
    tbl[9]  = '{70,  70,  8'h3C, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C};
    tbl[10] = '{79,  79,  8'hAA, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 8'hAA};
    tbl[11] = '{80,  79,  8'hAA, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01};
    tbl[12] = '{60,  80,  8'hAA, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01};
    tbl[13] = '{10,  127, 8'hAA, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC3};
    tbl[14] = '{10,  128, 8'hAA, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[15] = '{0,   137, 8'hAA, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[16] = '{0,   138, 8'hAA, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[17] = '{287, 139, 8'hAA, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[18] = '{0,   140, 8'hAA, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};

    repeat (3) tick(1'b1, 8'hAA, 8'h01);

    for (int i = 0; i < 19; i++) begin
      target = tbl[i].y * HT + tbl[i].x;
      while (p < target) tick(1'b0, 8'hAA, 8'h01);
      tick(1'b0, tbl[i].bx, tbl[i].bg);
      e = '{11'(tbl[i].x), 11'(tbl[i].y), tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].fs, tbl[i].rgb, 16'd0};
      check("table", e);
    end

    while (p < FT) tick(1'b0, 8'hAA, 8'h01);
    expect_int("de_count", decnt, 128 * 128);
    expect_int("frame_at_wrap", int'(frame), 1);

    while (p < FT + 50 * HT + 201) tick(1'b0, 8'hAA, 8'h01);
    expect_int("pre_rst_x", int'(pix_x), 200);
    expect_int("pre_rst_frame", int'(frame), 1);
    tick(1'b1, 8'hAA, 8'h01);
    tick(1'b0, 8'hAA, 8'h01);
    expect_int("post_rst_fs", int'(frame_start), 1);
    expect_int("post_rst_frame", int'(frame), 0);
    expect_int("post_rst_hsync", int'(hsync), 1);
    expect_int("post_rst_vsync", int'(vsync), 1);
    while (p < 61 * HT) tick(1'b0, 8'hAA, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster generator and sprite painter, successor to the fixed-geometry 128x128 controller. It generates hsync/vsync with configurable geometry and polarity, a registered data-enable, and pixel coordinates. It paints one rectangular sprite over a programmable background, and the sprite can optionally bounce around the active area once per frame. It sits between the 25 MHz pixel clock domain and the 3-3-2 RGB DAC pins.

## Interface
- H_ACTIVE, 128: visible pixels per line
- H_FP, 16: horizontal front porch, clocks
- H_SYNC, 96: hsync pulse width, clocks
- H_BP, 48: horizontal back porch, clocks
- V_ACTIVE, 128: visible lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vsync pulse width, lines
- V_BP, 33: vertical back porch, lines
- SYNC_POL, 0: sync active level (0 = active-low)
- BOX_W / BOX_H, 20 / 20: sprite size in pixels
- BOX_X0 / BOX_Y0, 60 / 60: sprite reset position
- STEP, 10: sprite displacement per frame, pixels
- FRAME_W, 16: frame counter width
- clk25mz  in  1  pixel clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- box_color  in  8  sprite colour {r[2:0],g[2:0],b[1:0]}, sampled every clock
- bg_color  in  8  background colour inside the active area, sampled every clock
- hsync, vsync  out  1  sync pulses at SYNC_POL level
- de  out  1  high while the output pixel is in the active area
- pix_x, pix_y  out  11  coordinates of the output pixel (raw counter values, including blanking)
- red, green  out  3  pixel colour
- blue  out  2  pixel colour
- frame  out  FRAME_W  completed-frame count; wraps modulo 2^FRAME_W
- frame_start  out  1  one-cycle pulse aligned with the output pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined likewise. The counters h and v are 11 bits wide.
- h counts from 0 to H_TOTAL-1 and then wraps to 0. v increments when h wraps, counts from 0 to V_TOTAL-1, and then wraps to 0.
- Active region: h<H_ACTIVE && v<V_ACTIVE.
- hsync is asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, which is exactly H_SYNC clocks.
- vsync is asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, which is exactly V_SYNC whole lines.
- Sprite hit: active && bx<=h<bx+BOX_W && by<=v<by+BOX_H.
- RGB output:
  - box_color on a sprite hit.
  - bg_color when active and not a hit.
  - 0 during blanking. This is mandatory for the DAC.
- End of frame is the cycle with h==H_TOTAL-1 && v==V_TOTAL-1. On that cycle:
  - frame increments.
  - The sprite position updates (see Configuration).
- The new sprite position applies from the next (0,0) onward. The position is never changed mid-frame.
- Sprite direction state: dx_neg and dy_neg, both reset to 0 (moving +x, +y).
- Legal parameters: BOX_W<=H_ACTIVE, BOX_H<=V_ACTIVE, 0<STEP, H_TOTAL and V_TOTAL < 2048. Anything else is unsupported.

## Timing
- Reset values:
  - h=v=0, frame=0, bx=BOX_X0, by=BOX_Y0, dx_neg=dy_neg=0.
  - hsync=vsync=!SYNC_POL.
  - de=0, frame_start=0, rgb=0, pix_x=pix_y=0.
- Latency: one clock.
  - All outputs are registered from the same counter state.
  - hsync, vsync, de, pix_x/pix_y, rgb and frame_start are therefore mutually aligned. No skew between them is permitted.
- First cycle after rst falls: counters are at (0,0). The outputs on the following edge show pixel (0,0) with frame_start=1.
- hsync output first goes active one clock after h reaches H_ACTIVE+H_FP.
- rst asserted mid-line: at the next edge all state returns to its reset values. No partial sync pulse may extend past that edge.
- box_color or bg_color changing mid-line takes effect on the next output pixel. There is no frame-level latching.

## Configuration
- Macro: VGA_BOUNCE_EN.
- Defined: at end of frame, each axis moves independently. The x axis behaves as follows (y is identical, using by, BOX_H and V_ACTIVE):
  - Moving +x: nx=bx+STEP. If nx>H_ACTIVE-BOX_W, then bx=H_ACTIVE-BOX_W and dx_neg=1. Otherwise bx=nx.
  - Moving -x: if bx<STEP, then bx=0 and dx_neg=0. Otherwise bx=bx-STEP.
- Undefined: bx/by hold at BOX_X0/BOX_Y0 permanently. The direction registers and the step logic are not synthesised. frame still counts.

## Test plan
- Reset and geometry check with defaults:
  - Exactly 288 clocks per line and 173 lines per frame.
  - hsync low for 96 clocks starting at output pix_x=144.
  - vsync low for 2 full lines starting at pix_y=138.
- Blanking: across one full frame, rgb==0 whenever de==0, and de is high for exactly 128*128 clocks.
- Static sprite (macro undefined, box_color=8'hAA, bg_color=8'h01):
  - Output is 8'hAA exactly for x 60..79, y 60..79 on every frame.
  - Output is 8'h01 elsewhere in the active area.
  - frame increments once per 288*173 clocks.
- Bounce (macro defined): sprite x origin per frame reads 60, 70, 80, 90, 100, 108, 98, 88, with y following the same sequence.
- Mid-frame reset: assert rst for one clock at pix_x=200, pix_y=50.
  - Next output is pixel (0,0) with frame=0 and sync inactive.
  - Sprite is back at (60,60).
- SYNC_POL=1 build: reset levels are hsync=vsync=0, and the pulses are high with the same widths and positions.
